md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 14 +
 rtl/md_if.sv | 14 +
 rtl/md_arith.sv | 23 ++
 rtl/md_unit.sv | 66 ++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared MD op codes, FSM states and default latencies (also used by the decoder)
package md_pkg;
  localparam logic [4:0] OP_MULTU = 5'd5;
  localparam logic [4:0] OP_MULT  = 5'd6;
  localparam logic [4:0] OP_DIVU  = 5'd7;
  localparam logic [4:0] OP_DIV   = 5'd8;
  localparam logic [4:0] OP_MFHI  = 5'd9;
  localparam logic [4:0] OP_MFLO  = 5'd10;
  localparam logic [4:0] OP_MTHI  = 5'd11;
  localparam logic [4:0] OP_MTLO  = 5'd12;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;
endpackage

// File: rtl/md_if.sv
// md_if: EX-stage request, read data, hazard and debug signals of the MD unit
interface md_if;
  logic        md_en;
  logic [4:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] md_result;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output md_en, md_op, src_a, src_b, input md_result, busy, stall, hi, lo);
  modport slave (input md_en, md_op, src_a, src_b, output md_result, busy, stall, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product, quotient and remainder of the latched operands
module md_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [63:0] prod,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  logic na, nb;
  logic [31:0] ma, mb, uq, ur;
  always_comb begin
    na = sgn & a[31];
    nb = sgn & b[31];
    prod = {{32{na}}, a} * {{32{nb}}, b};
    ma = na ? -a : a;
    mb = (b == '0) ? 32'd1 : (nb ? -b : b);
    uq = ma / mb;
    ur = ma % mb;
    quo = (na ^ nb) ? -uq : uq;
    rem = na ? -ur : ur;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and pipeline stall
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [31:0] op_a, op_b, hi_r, lo_r, quo, rem;
  logic [63:0] prod;
  logic op_sgn, legal, busy, stall, accept, is_mul, is_div, done;
  assign legal  = (md.md_op >= OP_MULTU) && (md.md_op <= OP_MTLO);
  assign busy   = state != S_IDLE;
  assign stall  = !reset && md.md_en && legal && busy;
  assign accept = md.md_en && legal && !stall;
  assign is_mul = (md.md_op == OP_MULTU) || (md.md_op == OP_MULT);
  assign is_div = (md.md_op == OP_DIVU) || (md.md_op == OP_DIV);
  assign done   = busy && (cnt == 8'd1);
  assign md.busy  = busy;
  assign md.stall = stall;
  assign md.hi    = hi_r;
  assign md.lo    = lo_r;
  assign md.md_result = (reset || !md.md_en || stall) ? '0 :
                        (md.md_op == OP_MFHI) ? hi_r :
                        (md.md_op == OP_MFLO) ? lo_r : '0;
  md_arith u_arith (.a(op_a), .b(op_b), .sgn(op_sgn), .prod(prod), .quo(quo), .rem(rem));
  always_comb begin
    state_nx = done ? S_IDLE :
               (accept && is_mul) ? S_MULT :
               (accept && is_div) ? S_DIV : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sgn <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state <= state_nx;
      if (accept && (is_mul || is_div)) begin
        cnt    <= is_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
        op_a   <= md.src_a;
        op_b   <= md.src_b;
        op_sgn <= (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
      end else if (busy) begin
        cnt <= cnt - 8'd1;
      end
      if (done && state == S_MULT) {hi_r, lo_r} <= prod;
      // a zero divisor burns the full latency but leaves HI/LO untouched
      if (done && state == S_DIV && op_b != '0) begin
        hi_r <= rem;
        lo_r <= quo;
      end
      if (accept && md.md_op == OP_MTHI) hi_r <= md.src_a;
      if (accept && md.md_op == OP_MTLO) lo_r <= md.src_a;
    end
  end
endmodule
